// File: rtl/glyph_string_draw.sv
// rtl/glyph_string_draw.sv - erase/redraw engine for a left-to-right string of monochrome glyph bitmaps
// Emits one registered pixel per cycle: an optional black erase of the previous string, then the new one.
module glyph_string_draw #(
   parameter int GLYPH_W    = 12,
   parameter int GLYPH_H    = 12,
   parameter int NUM_GLYPHS = 3,
   parameter int GAP        = 0
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyphs,
   input  logic [7:0]                            x,
   input  logic [6:0]                            y,
   input  logic [2:0]                            colour_in,
   input  logic                                  start,
   input  logic                                  clear_req,
   output logic [7:0]                            x_out,
   output logic [6:0]                            y_out,
   output logic [2:0]                            colour,
   output logic                                  writeEn,
   output logic                                  busy,
   output logic                                  done
);
   localparam int P     = NUM_GLYPHS * GLYPH_W * GLYPH_H;
   localparam int CW    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
   localparam int RW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
   localparam int GW    = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
   localparam int PITCH = GLYPH_W + GAP;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] DRAW  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state;
   logic [GW-1:0] g_q, g_n;
   logic [RW-1:0] r_q, r_n;
   logic [CW-1:0] c_q, c_n;
   logic [P-1:0]  bits_q, bits_sh;
   logic [7:0]    new_x, old_x, pass_x, x_nxt;
   logic [6:0]    new_y, old_y, pass_y, y_nxt;
   logic [2:0]    new_col;
   logic          drawn, redraw, last;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Column innermost, then row, then glyph.
   always_comb begin
      c_n = c_q + 1'b1;
      r_n = r_q;
      g_n = g_q;
      if (c_q == CW'(GLYPH_W - 1)) begin
         c_n = '0;
         if (r_q == RW'(GLYPH_H - 1)) begin
            r_n = '0;
            g_n = g_q + 1'b1;
         end else begin
            r_n = r_q + 1'b1;
         end
      end
   end

   assign last = (g_q == GW'(NUM_GLYPHS - 1)) && (r_q == RW'(GLYPH_H - 1)) &&
                 (c_q == CW'(GLYPH_W - 1));

   // Erase walks the previously drawn origin; draw walks the newly latched one.
   assign pass_x  = (state == CLEAR) ? old_x : new_x;
   assign pass_y  = (state == CLEAR) ? old_y : new_y;
   assign x_nxt   = pass_x + 8'(int'(g_n) * PITCH) + 8'(c_n);
   assign y_nxt   = pass_y + 7'(r_n);
   // Bitmap order matches scan order, so the current pixel is always the MSB.
   assign bits_sh = bits_q << 1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         g_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         bits_q  <= '0;
         new_x   <= '0;
         new_y   <= '0;
         new_col <= '0;
         old_x   <= '0;
         old_y   <= '0;
         drawn   <= 1'b0;
         redraw  <= 1'b0;
         x_out   <= '0;
         y_out   <= '0;
         colour  <= '0;
         writeEn <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               g_q <= '0;
               r_q <= '0;
               c_q <= '0;
               if (start) begin
                  bits_q  <= glyphs;
                  new_x   <= x;
                  new_y   <= y;
                  new_col <= colour_in;
                  redraw  <= 1'b1;
                  if (drawn) begin
                     state   <= CLEAR;
                     x_out   <= old_x;
                     y_out   <= old_y;
                     colour  <= '0;
                     writeEn <= 1'b1;
                  end else begin
                     state   <= DRAW;
                     x_out   <= x;
                     y_out   <= y;
                     colour  <= colour_in;
                     writeEn <= glyphs[P-1];
                  end
               end else if (clear_req) begin
                  redraw <= 1'b0;
                  if (drawn) begin
                     state   <= CLEAR;
                     x_out   <= old_x;
                     y_out   <= old_y;
                     colour  <= '0;
                     writeEn <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            CLEAR: begin
               if (last) begin
                  g_q <= '0;
                  r_q <= '0;
                  c_q <= '0;
                  if (redraw) begin
                     state   <= DRAW;
                     x_out   <= new_x;
                     y_out   <= new_y;
                     colour  <= new_col;
                     writeEn <= bits_q[P-1];
                  end else begin
                     state   <= DONE;
                     drawn   <= 1'b0;
                     colour  <= '0;
                     writeEn <= 1'b0;
                  end
               end else begin
                  g_q   <= g_n;
                  r_q   <= r_n;
                  c_q   <= c_n;
                  x_out <= x_nxt;
                  y_out <= y_nxt;
               end
            end
            DRAW: begin
               if (last) begin
                  state   <= DONE;
                  drawn   <= 1'b1;
                  old_x   <= new_x;
                  old_y   <= new_y;
                  colour  <= '0;
                  writeEn <= 1'b0;
               end else begin
                  g_q     <= g_n;
                  r_q     <= r_n;
                  c_q     <= c_n;
                  bits_q  <= bits_sh;
                  writeEn <= bits_sh[P-1];
                  x_out   <= x_nxt;
                  y_out   <= y_nxt;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_glyph_string_draw.sv
// tb/tb_glyph_string_draw.sv - randomized self-checking bench for glyph_string_draw
`timescale 1ns/1ps
module tb_glyph_string_draw;
   localparam int W   = 12;
   localparam int H   = 12;
   localparam int NG  = 3;
   localparam int GAP = 0;
   localparam int P   = NG * W * H;

   logic         clk = 1'b0;
   logic         resetn;
   logic [P-1:0] glyphs;
   logic [7:0]   x;
   logic [6:0]   y;
   logic [2:0]   colour_in;
   logic         start;
   logic         clear_req;
   logic [7:0]   x_out;
   logic [6:0]   y_out;
   logic [2:0]   colour;
   logic         writeEn;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: what the screen should currently hold.
   bit         m_drawn;
   logic [7:0] m_dx, m_lx;
   logic [6:0] m_dy, m_ly;

   typedef struct packed {
      logic       we;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] col;
   } pix_t;
   pix_t exp_q[$];

   always #5 clk = ~clk;

   glyph_string_draw #(.GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(NG), .GAP(GAP)) dut (
      .clk(clk), .resetn(resetn), .glyphs(glyphs), .x(x), .y(y),
      .colour_in(colour_in), .start(start), .clear_req(clear_req),
      .x_out(x_out), .y_out(y_out), .colour(colour), .writeEn(writeEn),
      .busy(busy), .done(done)
   );

   function automatic logic [P-1:0] rand_glyphs();
      logic [P-1:0] v;
      for (int i = 0; i < P; i++) v[i] = 1'($urandom);
      return v;
   endfunction

   function automatic logic [P-1:0] glyph0_ones();
      logic [P-1:0] v;
      v = '0;
      for (int i = 0; i < W * H; i++) v[P-1-i] = 1'b1;
      return v;
   endfunction

   task automatic add_pass(input logic [P-1:0] gl, input logic [7:0] ox, input logic [6:0] oy,
                           input logic [2:0] col, input bit is_clear);
      pix_t p;
      for (int g = 0; g < NG; g++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
               p.px  = 8'((int'(ox) + g * (W + GAP) + c) % 256);
               p.py  = 7'((int'(oy) + r) % 128);
               p.we  = is_clear ? 1'b1 : gl[P-1-(g*W*H + r*W + c)];
               p.col = is_clear ? 3'b000 : col;
               exp_q.push_back(p);
            end
   endtask

   task automatic model_reset();
      m_drawn = 0;
      m_dx = '0; m_dy = '0;
      m_lx = '0; m_ly = '0;
   endtask

   task automatic run_op(input string name, input logic [P-1:0] gl, input logic [7:0] ox,
                         input logic [6:0] oy, input logic [2:0] col,
                         input bit s, input bit cr, input bit noise);
      int k, nwr, exp_wr;
      exp_q.delete();
      if (s) begin
         if (m_drawn) add_pass('0, m_dx, m_dy, 3'b000, 1'b1);
         add_pass(gl, ox, oy, col, 1'b0);
      end else if (cr && m_drawn) begin
         add_pass('0, m_dx, m_dy, 3'b000, 1'b1);
      end
      exp_wr = 0;
      foreach (exp_q[i]) if (exp_q[i].we) exp_wr++;

      @(negedge clk);
      glyphs = gl; x = ox; y = oy; colour_in = col; start = s; clear_req = cr;
      @(negedge clk);
      start = 1'b0; clear_req = 1'b0;
      k = (noise && exp_q.size() > 20) ? $urandom_range(5, exp_q.size() - 10) : -10;
      nwr = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == k) begin
            start = 1'b1; clear_req = 1'b1; x = 8'($urandom); glyphs = ~gl;
         end
         if (i == k + 1) begin
            start = 1'b0; clear_req = 1'b0;
         end
         n_checks++;
         if ({busy, done, writeEn, x_out, y_out, colour} !== {2'b10, exp_q[i]}) begin
            n_fail++;
            $display("FAIL %s pixel %0d: got busy=%b done=%b we=%b x=%0d y=%0d col=%b, expected busy=1 done=0 we=%b x=%0d y=%0d col=%b",
                     name, i, busy, done, writeEn, x_out, y_out, colour,
                     exp_q[i].we, exp_q[i].px, exp_q[i].py, exp_q[i].col);
         end
         if (writeEn === 1'b1) nwr++;
         m_lx = exp_q[i].px;
         m_ly = exp_q[i].py;
         @(negedge clk);
      end
      n_checks++;
      if ({busy, done, writeEn, colour, x_out, y_out} !== {3'b110, 3'b000, m_lx, m_ly}) begin
         n_fail++;
         $display("FAIL %s done_cycle: got busy=%b done=%b we=%b col=%b x=%0d y=%0d, expected 1 1 0 000 x=%0d y=%0d",
                  name, busy, done, writeEn, colour, x_out, y_out, m_lx, m_ly);
      end
      n_checks++;
      if (nwr != exp_wr) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d expected %0d", name, nwr, exp_wr);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, done, writeEn} !== 3'b000) begin
         n_fail++;
         $display("FAIL %s idle_after: got busy=%b done=%b we=%b expected 000", name, busy, done, writeEn);
      end
      if (s) begin
         m_drawn = 1; m_dx = ox; m_dy = oy;
      end else if (cr) begin
         m_drawn = 0;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; clear_req = 1'b0;
      glyphs = '0; x = '0; y = '0; colour_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, writeEn, colour, x_out, y_out} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b we=%b col=%b x=%0d y=%0d, expected all zero",
                  busy, done, writeEn, colour, x_out, y_out);
      end
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_first_draw();
      run_op("first_draw", glyph0_ones(), 8'd10, 7'd20, 3'b101, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_redraw();
      run_op("redraw", glyph0_ones(), 8'd40, 7'd50, 3'b101, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      run_op("busy_ignore", rand_glyphs(), 8'($urandom), 7'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      run_op("wrap", glyph0_ones(), 8'd250, 7'd125, 3'b011, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_clear_req();
      run_op("clear_req", rand_glyphs(), 8'd0, 7'd0, 3'b111, 1'b0, 1'b1, 1'b0);
      run_op("clear_req_again", rand_glyphs(), 8'd0, 7'd0, 3'b111, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_draw();
      run_op("pre_reset_draw", rand_glyphs(), 8'($urandom), 7'($urandom), 3'b110, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      glyphs = glyph0_ones(); x = 8'd77; y = 7'd33; colour_in = 3'b010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, writeEn, colour, x_out, y_out} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_mid_draw: got busy=%b done=%b we=%b col=%b x=%0d y=%0d, expected all zero",
                  busy, done, writeEn, colour, x_out, y_out);
      end
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      run_op("after_reset_draw", rand_glyphs(), 8'($urandom), 7'($urandom), 3'b001, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int op;
      for (int n = 0; n < 6; n++) begin
         op = $urandom_range(0, 2);
         run_op((op == 0) ? "rand_start" : (op == 1) ? "rand_clear" : "rand_both",
                rand_glyphs(), 8'($urandom), 7'($urandom), 3'($urandom),
                op != 1, op != 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_redraw();
      test_busy_ignore();
      test_wrap();
      test_clear_req();
      test_reset_mid_draw();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
